// File: rtl/mig_jtag_tap_if.sv
// JTAG pin bundle and USER data-register hooks for mig_jtag_tap.
// The master side is the remote-bitbang driver; the slave side is the TAP.
interface mig_jtag_tap_if;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        trstn;
    logic        tdo;
    logic        tdo_en;
    logic [31:0] user_dr_in;
    logic [31:0] user_dr_out;
    logic        user_dr_capture;
    logic        user_dr_update;

    modport master (
        output tck, tms, tdi, trstn, user_dr_in,
        input  tdo, tdo_en, user_dr_out, user_dr_capture, user_dr_update
    );

    modport slave (
        input  tck, tms, tdi, trstn, user_dr_in,
        output tdo, tdo_en, user_dr_out, user_dr_capture, user_dr_update
    );
endinterface

// File: rtl/mig_jtag_tap.sv
// IEEE 1149.1 TAP responder with IDCODE, BYPASS and a 32-bit USER data register.
// All JTAG pins are oversampled and edge-detected in the single clk domain.
module mig_jtag_tap #(
    parameter logic [31:0] IDCODE   = 32'h1000_0CF1,
    parameter int          IR_WIDTH = 5
) (
    input logic           clk,
    input logic           rstn,
    mig_jtag_tap_if.slave tap
);

    // Standard 1149.1 state encoding, so the value is recognisable in a waveform.
    localparam logic [3:0] TLR      = 4'hF;
    localparam logic [3:0] RTI      = 4'hC;
    localparam logic [3:0] SEL_DR   = 4'h7;
    localparam logic [3:0] CAP_DR   = 4'h6;
    localparam logic [3:0] SH_DR    = 4'h2;
    localparam logic [3:0] EX1_DR   = 4'h1;
    localparam logic [3:0] PAUSE_DR = 4'h3;
    localparam logic [3:0] EX2_DR   = 4'h0;
    localparam logic [3:0] UPD_DR   = 4'h5;
    localparam logic [3:0] SEL_IR   = 4'h4;
    localparam logic [3:0] CAP_IR   = 4'hE;
    localparam logic [3:0] SH_IR    = 4'hA;
    localparam logic [3:0] EX1_IR   = 4'h9;
    localparam logic [3:0] PAUSE_IR = 4'hB;
    localparam logic [3:0] EX2_IR   = 4'h8;
    localparam logic [3:0] UPD_IR   = 4'hD;

    // Any opcode other than these two behaves as BYPASS.
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
    localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(5'h10);

    logic [1:0]          tckSync_q;
    logic [1:0]          tmsSync_q;
    logic [1:0]          tdiSync_q;
    logic [1:0]          trstnSync_q;
    logic                tckPrev_q;

    logic [3:0]          tapState_q,  tapState_d;
    logic [IR_WIDTH-1:0] ir_q,        ir_d;
    logic [IR_WIDTH-1:0] irShift_q,   irShift_d;
    logic [31:0]         drShift_q,   drShift_d;
    logic                bypass_q,    bypass_d;
    logic [31:0]         userOut_q,   userOut_d;
    logic                capture_q,   capture_d;
    logic                update_q,    update_d;
    logic                tdo_q,       tdo_d;
    logic                tdoEn_q,     tdoEn_d;

    logic                tckRise;
    logic                tckFall;
    logic                tmsS;
    logic                tdiS;
    logic                trstnS;
    logic                isIdcode;
    logic                isUser;
    logic                isBypass;
    logic [3:0]          stateNext;

    assign tckRise  = tckSync_q[1] & ~tckPrev_q;
    assign tckFall  = ~tckSync_q[1] & tckPrev_q;
    assign tmsS     = tmsSync_q[1];
    assign tdiS     = tdiSync_q[1];
    assign trstnS   = trstnSync_q[1];

    assign isIdcode = (ir_q == IR_IDCODE);
    assign isUser   = (ir_q == IR_USER);
    assign isBypass = ~(isIdcode | isUser);

    always_comb begin
        stateNext = TLR;
        case (tapState_q)
            TLR:      stateNext = tmsS ? TLR      : RTI;
            RTI:      stateNext = tmsS ? SEL_DR   : RTI;
            SEL_DR:   stateNext = tmsS ? SEL_IR   : CAP_DR;
            CAP_DR:   stateNext = tmsS ? EX1_DR   : SH_DR;
            SH_DR:    stateNext = tmsS ? EX1_DR   : SH_DR;
            EX1_DR:   stateNext = tmsS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: stateNext = tmsS ? EX2_DR   : PAUSE_DR;
            EX2_DR:   stateNext = tmsS ? UPD_DR   : SH_DR;
            UPD_DR:   stateNext = tmsS ? SEL_DR   : RTI;
            SEL_IR:   stateNext = tmsS ? TLR      : CAP_IR;
            CAP_IR:   stateNext = tmsS ? EX1_IR   : SH_IR;
            SH_IR:    stateNext = tmsS ? EX1_IR   : SH_IR;
            EX1_IR:   stateNext = tmsS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: stateNext = tmsS ? EX2_IR   : PAUSE_IR;
            EX2_IR:   stateNext = tmsS ? UPD_IR   : SH_IR;
            UPD_IR:   stateNext = tmsS ? SEL_DR   : RTI;
            default:  stateNext = TLR;
        endcase
    end

    // Capture, shift and update all act on the rise that leaves the state, so
    // the USER pulses line up with the clk in which the FSM moves on.
    always_comb begin
        tapState_d = tapState_q;
        ir_d       = ir_q;
        irShift_d  = irShift_q;
        drShift_d  = drShift_q;
        bypass_d   = bypass_q;
        userOut_d  = userOut_q;
        capture_d  = 1'b0;
        update_d   = 1'b0;
        tdo_d      = tdo_q;
        tdoEn_d    = tdoEn_q;

        if (!trstnS) begin
            tapState_d = TLR;
            ir_d       = IR_IDCODE;
        end else begin
            if (tapState_q == TLR) begin
                ir_d = IR_IDCODE;
            end
            if (tckRise) begin
                tapState_d = stateNext;
                case (tapState_q)
                    CAP_IR: irShift_d = IR_WIDTH'(1);
                    SH_IR:  irShift_d = {tdiS, irShift_q[IR_WIDTH-1:1]};
                    UPD_IR: ir_d      = irShift_q;
                    CAP_DR: begin
                        if (isIdcode) begin
                            drShift_d = IDCODE;
                        end else if (isUser) begin
                            drShift_d = tap.user_dr_in;
                            capture_d = 1'b1;
                        end else begin
                            bypass_d  = 1'b0;
                        end
                    end
                    SH_DR: begin
                        if (isBypass) begin
                            bypass_d  = tdiS;
                        end else begin
                            drShift_d = {tdiS, drShift_q[31:1]};
                        end
                    end
                    UPD_DR: begin
                        if (isUser) begin
                            userOut_d = drShift_q;
                            update_d  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // TDO only moves on a fall so it is settled long before the next rise.
        if (tckFall) begin
            tdoEn_d = (tapState_q == SH_IR) || (tapState_q == SH_DR);
            if (tapState_q == SH_IR) begin
                tdo_d = irShift_q[0];
            end else if (tapState_q == SH_DR) begin
                tdo_d = isBypass ? bypass_q : drShift_q[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tckSync_q   <= '0;
            tmsSync_q   <= '0;
            tdiSync_q   <= '0;
            trstnSync_q <= '0;
            tckPrev_q   <= 1'b0;
            tapState_q  <= TLR;
            ir_q        <= IR_IDCODE;
            irShift_q   <= '0;
            drShift_q   <= '0;
            bypass_q    <= 1'b0;
            userOut_q   <= '0;
            capture_q   <= 1'b0;
            update_q    <= 1'b0;
            tdo_q       <= 1'b0;
            tdoEn_q     <= 1'b0;
        end else begin
            tckSync_q   <= {tckSync_q[0], tap.tck};
            tmsSync_q   <= {tmsSync_q[0], tap.tms};
            tdiSync_q   <= {tdiSync_q[0], tap.tdi};
            trstnSync_q <= {trstnSync_q[0], tap.trstn};
            tckPrev_q   <= tckSync_q[1];
            tapState_q  <= tapState_d;
            ir_q        <= ir_d;
            irShift_q   <= irShift_d;
            drShift_q   <= drShift_d;
            bypass_q    <= bypass_d;
            userOut_q   <= userOut_d;
            capture_q   <= capture_d;
            update_q    <= update_d;
            tdo_q       <= tdo_d;
            tdoEn_q     <= tdoEn_d;
        end
    end

    assign tap.tdo             = tdo_q;
    assign tap.tdo_en          = tdoEn_q;
    assign tap.user_dr_out     = userOut_q;
    assign tap.user_dr_capture = capture_q;
    assign tap.user_dr_update  = update_q;

endmodule
